serial_out: RTL and testbench

SERIAL_OUT -- requirements
Module: serial_out

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_out_shifter.sv | 113 +++++++++++
 rtl/serial_out.sv | 135 +++++++++++++
 tb/tb_serial_out.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial_out / serial_in pair: field geometry,
// FSM state encoding and the first-bit helper.
// No ports.
package serial_pkg;

    localparam int unsigned LENGTH       = 16;
    localparam int unsigned MAX_FEATURES = 15;
    localparam int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int unsigned FEAT_W       = 4;
    // Wide enough to hold DATA_WIDTH-1 = 255 without wrap.
    localparam int unsigned CNT_W        = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } state_e;

    // Index of the first emitted bit: the top feat+1 fields of the word are sent.
    function automatic logic [CNT_W-1:0] first_bit(input int unsigned       data_w,
                                                   input int unsigned       len,
                                                   input logic [FEAT_W-1:0] feat);
        return CNT_W'(data_w - len * (32'(feat) + 32'd1));
    endfunction

endpackage

// File: rtl/serial_out_shifter.sv
// Word shift register for serial_out: loads a memory word aligned to its first
// emitted bit, then presents one bit per step, LSB-first, up to DATA_WIDTH-1.
// Optional macro SERIAL_OUT_PARITY_EN adds a trailing even-parity bit per word.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   load_i         capture rd_data_i (first bit appears on ser_o next cycle)
//   step_i         advance to the next bit
//   init_i         index of the first bit to emit
//   rd_data_i      memory word
//   ser_o          current serial bit (registered, 0 once a word is finished)
//   last_c_o       current bit is the final one of the word (combinational)
module serial_out_shifter #(
    parameter int unsigned DATA_WIDTH = serial_pkg::DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_i,
    input  logic                         step_i,
    input  logic [serial_pkg::CNT_W-1:0] init_i,
    input  logic [DATA_WIDTH-1:0]        rd_data_i,
    output logic                         ser_o,
    output logic                         last_c_o
);
    import serial_pkg::*;

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] load_c;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic                  ser_q, ser_d;
    logic                  at_end_c;
`ifdef SERIAL_OUT_PARITY_EN
    logic                  par_q, par_d;
    logic                  par_ph_q, par_ph_d;
`endif

    // Word pre-shifted so the first emitted bit sits at position 0.
    assign load_c   = rd_data_i >> init_i;
    assign at_end_c = (idx_q == CNT_W'(DATA_WIDTH - 1));

`ifdef SERIAL_OUT_PARITY_EN
    assign last_c_o = par_ph_q;
`else
    assign last_c_o = at_end_c;
`endif

    assign ser_o = ser_q;

    // Next-state: load, step, or hold current contents.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        ser_d = ser_q;
`ifdef SERIAL_OUT_PARITY_EN
        par_d    = par_q;
        par_ph_d = par_ph_q;
`endif
        if (load_i) begin
            sr_d  = load_c >> 1;
            ser_d = load_c[0];
            idx_d = init_i;
`ifdef SERIAL_OUT_PARITY_EN
            par_d    = load_c[0];
            par_ph_d = 1'b0;
`endif
        end else if (step_i) begin
`ifdef SERIAL_OUT_PARITY_EN
            if (par_ph_q) begin
                ser_d    = 1'b0;
                par_ph_d = 1'b0;
            end else if (at_end_c) begin
                // Even parity over the emitted bits: the XOR of them all.
                ser_d    = par_q;
                par_ph_d = 1'b1;
            end else begin
                ser_d = sr_q[0];
                sr_d  = sr_q >> 1;
                idx_d = idx_q + CNT_W'(1);
                par_d = par_q ^ sr_q[0];
            end
`else
            if (at_end_c) begin
                ser_d = 1'b0;
            end else begin
                ser_d = sr_q[0];
                sr_d  = sr_q >> 1;
                idx_d = idx_q + CNT_W'(1);
            end
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            idx_q <= '0;
            ser_q <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            par_q    <= 1'b0;
            par_ph_q <= 1'b0;
`endif
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
            ser_q <= ser_d;
`ifdef SERIAL_OUT_PARITY_EN
            par_q    <= par_d;
            par_ph_q <= par_ph_d;
`endif
        end
    end

endmodule

// File: rtl/serial_out.sv
// Reads words 0..num_dp from memory and serialises the top (feat+1) LENGTH-bit
// fields of each word, LSB-first. hold freezes everything.
// Optional macro SERIAL_OUT_PARITY_EN: one even-parity bit after every word.
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   start               begin a transfer (accepted in IDLE only)
//   num_dp              last address to send, inclusive
//   feat                number of fields per word minus 1
//   hold                stall; also masks rd_en and ser_valid
//   rd_en, rd_addr      memory read strobe and address
//   rd_data             memory data, valid the cycle after rd_en
//   ser, ser_valid      serial bit and its qualifier
//   busy                transfer in progress
//   done                one-cycle pulse after the last bit
module serial_out #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MAX_FEATURES = serial_pkg::MAX_FEATURES,
    parameter int unsigned LENGTH       = serial_pkg::LENGTH,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [11:0]           num_dp,
    input  logic [3:0]            feat,
    input  logic                  hold,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ser,
    output logic                  ser_valid,
    output logic                  busy,
    output logic                  done
);
    import serial_pkg::*;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] num_dp_q;
    logic [FEAT_W-1:0]     feat_q;
    logic                  rd_en_q;
    logic                  ser_valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [FEAT_W-1:0]     feat_eff_c;
    logic [CNT_W-1:0]      init_c;
    logic                  load_c;
    logic                  step_c;
    logic                  word_last_c;

    // Clamp out-of-range feature counts to the configured maximum.
    assign feat_eff_c = (32'(feat_q) > MAX_FEATURES) ? FEAT_W'(MAX_FEATURES) : feat_q;
    assign init_c     = first_bit(DATA_WIDTH, LENGTH, feat_eff_c);

    assign load_c = (state_q == WAIT)  && !hold;
    assign step_c = (state_q == SHIFT) && !hold;

    serial_out_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .load_i    (load_c),
        .step_i    (step_c),
        .init_i    (init_c),
        .rd_data_i (rd_data),
        .ser_o     (ser),
        .last_c_o  (word_last_c)
    );

    // Strobes are masked the same cycle hold rises; everything else freezes.
    assign rd_en     = rd_en_q & ~hold;
    assign ser_valid = ser_valid_q & ~hold;
    assign rd_addr   = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Control FSM with outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            num_dp_q    <= '0;
            feat_q      <= '0;
            rd_en_q     <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (!hold) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FETCH;
                        num_dp_q <= ADDR_WIDTH'(num_dp);
                        feat_q   <= feat;
                        addr_q   <= '0;
                        rd_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= WAIT;
                    rd_en_q <= 1'b0;
                end
                WAIT: begin
                    state_q     <= SHIFT;
                    ser_valid_q <= 1'b1;
                end
                SHIFT: begin
                    if (word_last_c) begin
                        ser_valid_q <= 1'b0;
                        if (addr_q == num_dp_q) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            addr_q  <= addr_q + ADDR_WIDTH'(1);
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_out.sv
// Self-checking bench for serial_out: a vector table of transfer scenarios,
// hand-written reset/start corner cases and randomized transfers, all checked
// against a bit-queue model built from the memory contents.
module tb_serial_out;

    localparam int DW     = 256;
    localparam int BUDGET = 6000;
`ifdef SERIAL_OUT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            start;
    logic [11:0]     num_dp;
    logic [3:0]      feat;
    logic            hold;
    logic            rd_en;
    logic [11:0]     rd_addr;
    logic [DW-1:0]   rd_data = '0;
    logic            ser;
    logic            ser_valid;
    logic            busy;
    logic            done;

    always #5 CLK = ~CLK;

    serial_out dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .num_dp    (num_dp),
        .feat      (feat),
        .hold      (hold),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ser       (ser),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    // Memory: 16 words, addressed by the low address bits, one-cycle latency.
    logic [DW-1:0] mem [16];
    always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr[3:0]];

    bit  exp_bits [$];
    int  exp_addr [$];
    int  checks, errors;
    int  nvalid, nrd, ndone, cyc, last_valid_cyc;
    bit  hold_seen, mon_en, last_bit;

    typedef struct {
        int feat;
        int num_dp;
        int hold_at;
        int hold_len;
        int restart_at;
        bit fin_start;
        int exp_bits;
        int exp_words;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < DW / 32; k++)
                mem[i][k*32 +: 32] = $urandom;
    endtask

    // Reference: every word 0..n contributes its top 16*(f+1) bits, low first.
    task automatic setup_expect(input int f, input int n);
        logic [DW-1:0] w;
        bit            p;
        exp_bits.delete();
        exp_addr.delete();
        nvalid = 0; nrd = 0; ndone = 0; hold_seen = 0;
        last_valid_cyc = cyc;
        for (int a = 0; a <= n; a++) begin
            w = mem[a % 16];
            p = 1'b0;
            exp_addr.push_back(a);
            for (int i = DW - 16 * (f + 1); i < DW; i++) begin
                exp_bits.push_back(w[i]);
                p ^= w[i];
            end
`ifdef SERIAL_OUT_PARITY_EN
            exp_bits.push_back(p);
`endif
        end
        mon_en = 1'b1;
    endtask

    task automatic monitor_step();
        cyc++;
        if (!mon_en) return;
        if (hold) begin
            hold_seen = 1'b1;
            chk("hold_ser_valid", 32'(ser_valid), 0);
            chk("hold_rd_en", 32'(rd_en), 0);
        end
        if (rd_en) begin
            nrd++;
            if (exp_addr.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_extra got addr %0d expected no read", rd_addr);
            end else begin
                chk("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
            end
        end
        if (ser_valid) begin
            if (nvalid > 0 && cyc != last_valid_cyc + 1 && !hold_seen)
                chk("word_gap", 32'(cyc - last_valid_cyc - 1), 2);
            hold_seen = 1'b0;
            if (exp_bits.size() == 0) begin
                checks++; errors++;
                $display("FAIL ser_extra got bit %0d expected no bit", ser);
            end else begin
                chk("ser_bit", 32'(ser), 32'(exp_bits.pop_front()));
            end
            nvalid++;
            last_valid_cyc = cyc;
            last_bit = ser;
        end else if (!hold) begin
            chk("ser_idle", 32'(ser), 0);
        end
        if (done) begin
            ndone++;
            chk("done_timing", 32'(cyc - last_valid_cyc), 1);
            chk("done_bits_left", 32'(exp_bits.size()), 0);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        monitor_step();
    end

    // Start pulse, then scramble the inputs to prove they were latched.
    task automatic pulse_start(input int f, input int n);
        feat = 4'(f); num_dp = 12'(n); start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; feat = 4'($urandom); num_dp = 12'($urandom);
        chk("first_rd_en", 32'(rd_en), 1);
        chk("first_rd_addr", 32'(rd_addr), 0);
        chk("busy_start", 32'(busy), 1);
    endtask

    // Runs until done; ends one cycle after FIN (IDLE), bounded by BUDGET.
    task automatic run_body(input int hold_at, input int hold_len, input int restart_at, input bit fin_start);
        bit held = 1'b0;
        bit restarted = 1'b0;
        bit fin_seen = 1'b0;
        for (int c = 0; c < BUDGET && !fin_seen; c++) begin
            if (!held && hold_at >= 0 && nvalid == hold_at) begin
                held = 1'b1; hold = 1'b1;
                repeat (hold_len) begin @(posedge CLK); #1; end
                hold = 1'b0;
            end
            if (!restarted && restart_at >= 0 && nvalid == restart_at) begin
                restarted = 1'b1; start = 1'b1;
                @(posedge CLK); #1;
                start = 1'b0;
            end
            if (done) begin
                fin_seen = 1'b1;
                chk("busy_fin", 32'(busy), 1);
                if (fin_start) start = 1'b1;
                @(posedge CLK); #1;
                start = 1'b0;
                chk("busy_idle", 32'(busy), 0);
                chk("done_one_cycle", 32'(done), 0);
            end else begin
                @(posedge CLK); #1;
            end
        end
        if (!fin_seen) begin
            checks++; errors++;
            $display("FAIL timeout got no done expected done within %0d cycles", BUDGET);
        end
    endtask

    task automatic finish_xfer(input int bits, input int words);
        chk("done_count", 32'(ndone), 1);
        chk("bits_left", 32'(exp_bits.size()), 0);
        chk("addr_left", 32'(exp_addr.size()), 0);
        chk("bit_count", 32'(nvalid), 32'(bits + words * PB));
        chk("rd_count", 32'(nrd), 32'(words));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  f, n, tot, ha, hl;
        bit  reached;
        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        nvalid = 0; nrd = 0; ndone = 0; last_valid_cyc = 0; hold_seen = 0; last_bit = 0;
        RST_N = 1'b0; start = 1'b0; hold = 1'b0; feat = '0; num_dp = '0;

        vecs[0] = '{15, 0,  -1, 0, -1, 1'b0, 256, 1};
        vecs[1] = '{ 0, 2,  -1, 0, -1, 1'b0,  48, 3};
        vecs[2] = '{15, 0, 100, 5, -1, 1'b0, 256, 1};
        vecs[3] = '{ 0, 1,  16, 3, -1, 1'b0,  32, 2};
        vecs[4] = '{ 7, 2,  -1, 0,  5, 1'b0, 384, 3};
        vecs[5] = '{ 3, 1,  -1, 0, -1, 1'b1, 128, 2};
        vecs[6] = '{15, 1,  -1, 0, -1, 1'b0, 512, 2};

        fill_mem();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_ser_valid", 32'(ser_valid), 0);
        chk("rst_ser", 32'(ser), 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int v = 0; v < 7; v++) begin
            fill_mem();
            if (v == 0) mem[0] = {4{64'h0123456789ABCDEF}};
            setup_expect(vecs[v].feat, vecs[v].num_dp);
            pulse_start(vecs[v].feat, vecs[v].num_dp);
            run_body(vecs[v].hold_at, vecs[v].hold_len, vecs[v].restart_at, vecs[v].fin_start);
            finish_xfer(vecs[v].exp_bits, vecs[v].exp_words);
            if (vecs[v].fin_start) begin
                // Start in the first IDLE cycle after FIN must be taken.
                setup_expect(vecs[v].feat, vecs[v].num_dp);
                pulse_start(vecs[v].feat, vecs[v].num_dp);
                run_body(-1, 0, -1, 1'b0);
                finish_xfer(vecs[v].exp_bits, vecs[v].exp_words);
            end
            repeat (2) @(posedge CLK);
            #1;
        end

        // Parity corner: three ones in the sent field.
        fill_mem();
        mem[0][255:240] = 16'h0007;
        setup_expect(0, 0);
        pulse_start(0, 0);
        run_body(-1, 0, -1, 1'b0);
        finish_xfer(16, 1);
`ifdef SERIAL_OUT_PARITY_EN
        chk("parity_bit", 32'(last_bit), 1);
`else
        chk("last_data_bit", 32'(last_bit), 0);
`endif
        repeat (2) @(posedge CLK);
        #1;

        // Reset in word 1 of a four-word transfer, with hold and start also high.
        fill_mem();
        setup_expect(1, 3);
        pulse_start(1, 3);
        reached = 1'b0;
        for (int c = 0; c < BUDGET && !reached; c++) begin
            if (nvalid >= 35) reached = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reach_word1 got %0d bits expected 35", nvalid);
        end
        mon_en = 1'b0;
        RST_N = 1'b0; hold = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        RST_N = 1'b1; hold = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rd_en", 32'(rd_en), 0);
        chk("abort_ser_valid", 32'(ser_valid), 0);
        chk("abort_ser", 32'(ser), 0);
        chk("abort_rd_addr", 32'(rd_addr), 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
        end
        setup_expect(1, 3);
        pulse_start(1, 3);
        run_body(-1, 0, -1, 1'b0);
        finish_xfer(128, 4);
        repeat (2) @(posedge CLK);
        #1;

        // Randomized transfers, some with a hold burst.
        for (int r = 0; r < 8; r++) begin
            f   = int'($urandom_range(0, 15));
            n   = int'($urandom_range(0, 4));
            tot = 16 * (f + 1) * (n + 1);
            ha  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 32'(tot - 1))) : -1;
            hl  = int'($urandom_range(1, 4));
            fill_mem();
            setup_expect(f, n);
            pulse_start(f, n);
            run_body(ha, hl, -1, 1'b0);
            finish_xfer(tot, n + 1);
            repeat (int'($urandom_range(1, 3))) @(posedge CLK);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
